// File: rtl/vdp_cpu_vram_port_if.sv
// Bundle of the CPU port bus, VRAM arbiter toggle handshake and register-write strobes.
// Latency: n/a (wiring only).
// Backpressure: carried by the REQ/ACK toggle pairs; a request is pending while REQ != ACK.
//
// Ports (slave view = vdp_cpu_vram_port):
//   in : cpu_req, cpu_wr, cpu_port, cpu_din, addr_high, DOTSTATE, PRAMDBI,
//        VDPVRAMWRACK, VDPVRAMRDACK, VDPVRAMADDRSETACK, VDPVRAMREADINGR
//   out: cpu_dout, VDPVRAMWRREQ, VDPVRAMRDREQ, VDPVRAMADDRSETREQ, VDPVRAMACCESSDATA,
//        VDPVRAMACCESSADDRTMP, VDPVRAMREADINGA, reg_wr, reg_num, reg_data, wr_overrun
interface vdp_cpu_vram_port_if #(
   parameter int ADDR_W = 20
);
   logic              cpu_req;
   logic              cpu_wr;
   logic [1:0]        cpu_port;
   logic [7:0]        cpu_din;
   logic [7:0]        cpu_dout;
   logic [5:0]        addr_high;
   logic [1:0]        DOTSTATE;
   logic [7:0]        PRAMDBI;
   logic              VDPVRAMWRACK;
   logic              VDPVRAMRDACK;
   logic              VDPVRAMADDRSETACK;
   logic              VDPVRAMREADINGR;
   logic              VDPVRAMWRREQ;
   logic              VDPVRAMRDREQ;
   logic              VDPVRAMADDRSETREQ;
   logic [7:0]        VDPVRAMACCESSDATA;
   logic [ADDR_W-1:0] VDPVRAMACCESSADDRTMP;
   logic              VDPVRAMREADINGA;
   logic              reg_wr;
   logic [5:0]        reg_num;
   logic [7:0]        reg_data;
   logic              wr_overrun;

   modport master (
      output cpu_req, cpu_wr, cpu_port, cpu_din, addr_high, DOTSTATE, PRAMDBI,
             VDPVRAMWRACK, VDPVRAMRDACK, VDPVRAMADDRSETACK, VDPVRAMREADINGR,
      input  cpu_dout, VDPVRAMWRREQ, VDPVRAMRDREQ, VDPVRAMADDRSETREQ, VDPVRAMACCESSDATA,
             VDPVRAMACCESSADDRTMP, VDPVRAMREADINGA, reg_wr, reg_num, reg_data, wr_overrun
   );

   modport slave (
      input  cpu_req, cpu_wr, cpu_port, cpu_din, addr_high, DOTSTATE, PRAMDBI,
             VDPVRAMWRACK, VDPVRAMRDACK, VDPVRAMADDRSETACK, VDPVRAMREADINGR,
      output cpu_dout, VDPVRAMWRREQ, VDPVRAMRDREQ, VDPVRAMADDRSETREQ, VDPVRAMACCESSDATA,
             VDPVRAMACCESSADDRTMP, VDPVRAMREADINGA, reg_wr, reg_num, reg_data, wr_overrun
   );
endinterface

// File: rtl/vdp_cpu_vram_port.sv
// CPU-side VRAM front end: decodes data/control port bytes into VRAM toggle requests and register writes.
// Latency: requests, staged data/address and reg_wr appear 1 cycle after the access; cpu_dout is combinational.
// Backpressure: toggle handshake; a new request of a type is only issued when its REQ == ACK.
//
// Ports: CLK21M (clock), RESET (async, active-high), bus (vdp_cpu_vram_port_if.slave,
// CPU port bus + arbiter handshake + register-write strobes).
module vdp_cpu_vram_port #(
   parameter int ADDR_W = 20
) (
   input  logic                   CLK21M,
   input  logic                   RESET,
   vdp_cpu_vram_port_if.slave     bus
);

   logic              first_q,    first_d;
   logic [7:0]        low_q,      low_d;
   logic              wrreq_q,    wrreq_d;
   logic              rdreq_q,    rdreq_d;
   logic              asreq_q,    asreq_d;
   logic [7:0]        data_q,     data_d;
   logic [ADDR_W-1:0] addrtmp_q,  addrtmp_d;
   logic              readinga_q, readinga_d;
   logic [7:0]        rdbuf_q,    rdbuf_d;
   logic              reg_wr_q,   reg_wr_d;
   logic [5:0]        reg_num_q,  reg_num_d;
   logic [7:0]        reg_data_q, reg_data_d;
   logic              overrun_q,  overrun_d;

   // Pending checks use the registered REQ against the ack as sampled this edge.
   logic wr_idle, rd_idle, as_idle;
   assign wr_idle = (wrreq_q == bus.VDPVRAMWRACK);
   assign rd_idle = (rdreq_q == bus.VDPVRAMRDACK);
   assign as_idle = (asreq_q == bus.VDPVRAMADDRSETACK);

   always_comb begin
      first_d    = first_q;
      low_d      = low_q;
      wrreq_d    = wrreq_q;
      rdreq_d    = rdreq_q;
      asreq_d    = asreq_q;
      data_d     = data_q;
      addrtmp_d  = addrtmp_q;
      readinga_d = readinga_q;
      rdbuf_d    = rdbuf_q;
      reg_wr_d   = 1'b0;
      reg_num_d  = reg_num_q;
      reg_data_d = reg_data_q;
      overrun_d  = 1'b0;

      // Read-ahead capture runs regardless of CPU activity.
      if (bus.DOTSTATE == 2'b01 && bus.VDPVRAMREADINGR != readinga_q) begin
         rdbuf_d    = bus.PRAMDBI;
         readinga_d = bus.VDPVRAMREADINGR;
      end

      if (bus.cpu_req) begin
         if (bus.cpu_port == 2'd0) begin
            first_d = 1'b0;
            if (bus.cpu_wr) begin
               // A write arriving while one is pending replaces its byte in place.
               data_d = bus.cpu_din;
               if (wr_idle) wrreq_d = ~wrreq_q;
               else         overrun_d = 1'b1;
            end else if (rd_idle) begin
               rdreq_d = ~rdreq_q;
            end
         end else if (bus.cpu_port == 2'd1) begin
            if (!bus.cpu_wr) begin
               // Status read resynchronises the two-byte sequence.
               first_d = 1'b0;
            end else if (!first_q) begin
               low_d   = bus.cpu_din;
               first_d = 1'b1;
            end else begin
               first_d = 1'b0;
               if (bus.cpu_din[7]) begin
                  reg_wr_d   = 1'b1;
                  reg_num_d  = bus.cpu_din[5:0];
                  reg_data_d = low_q;
               end else begin
                  addrtmp_d = ADDR_W'({bus.addr_high, bus.cpu_din[5:0], low_q});
                  if (as_idle) asreq_d = ~asreq_q;
                  // Bit 6 clear means read setup: prefetch from the new address.
                  if (!bus.cpu_din[6] && rd_idle) rdreq_d = ~rdreq_q;
               end
            end
         end
      end
   end

   always_ff @(posedge CLK21M or posedge RESET) begin
      if (RESET) begin
         first_q    <= 1'b0;
         low_q      <= '0;
         wrreq_q    <= 1'b0;
         rdreq_q    <= 1'b0;
         asreq_q    <= 1'b0;
         data_q     <= '0;
         addrtmp_q  <= '0;
         readinga_q <= 1'b0;
         rdbuf_q    <= '0;
         reg_wr_q   <= 1'b0;
         reg_num_q  <= '0;
         reg_data_q <= '0;
         overrun_q  <= 1'b0;
      end else begin
         first_q    <= first_d;
         low_q      <= low_d;
         wrreq_q    <= wrreq_d;
         rdreq_q    <= rdreq_d;
         asreq_q    <= asreq_d;
         data_q     <= data_d;
         addrtmp_q  <= addrtmp_d;
         readinga_q <= readinga_d;
         rdbuf_q    <= rdbuf_d;
         reg_wr_q   <= reg_wr_d;
         reg_num_q  <= reg_num_d;
         reg_data_q <= reg_data_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.cpu_dout             = rdbuf_q;
   assign bus.VDPVRAMWRREQ         = wrreq_q;
   assign bus.VDPVRAMRDREQ         = rdreq_q;
   assign bus.VDPVRAMADDRSETREQ    = asreq_q;
   assign bus.VDPVRAMACCESSDATA    = data_q;
   assign bus.VDPVRAMACCESSADDRTMP = addrtmp_q;
   assign bus.VDPVRAMREADINGA      = readinga_q;
   assign bus.reg_wr               = reg_wr_q;
   assign bus.reg_num              = reg_num_q;
   assign bus.reg_data             = reg_data_q;
   assign bus.wr_overrun           = overrun_q;

endmodule

// File: doc/vdp_cpu_vram_port.md
Name: vdp_cpu_vram_port

Overview:
- CPU-side front end for VRAM access. It decodes the host data port (port 0) and control port (port 1) byte stream.
- It produces the toggle-handshake requests (write, read-ahead, address set) and the staged address/data consumed by the VRAM arbiter/address bus stage.
- It captures read-ahead data from the VRAM data bus into the CPU read buffer.
- It also forwards control-port register writes to the register file as strobes.

Parameters:
- ADDR_W, 20, width of the VRAM access address (bits 19:14 come from addr_high).

Ports:
- CLK21M  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- cpu_req  in  1  one-cycle strobe: a CPU port access occurs this cycle
- cpu_wr  in  1  1 = write, 0 = read (qualified by cpu_req)
- cpu_port  in  2  0 = data port, 1 = control port, 2/3 = ignored here
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  data-port read value (read buffer)
- addr_high  in  6  VRAM address bits 19:14 from the register file
- DOTSTATE  in  2  dot phase
- PRAMDBI  in  8  VRAM read data bus
- VDPVRAMWRACK, VDPVRAMRDACK, VDPVRAMADDRSETACK  in  1 each  arbiter ack toggles
- VDPVRAMREADINGR  in  1  arbiter "read issued" toggle
- VDPVRAMWRREQ, VDPVRAMRDREQ, VDPVRAMADDRSETREQ  out  1 each  request toggles
- VDPVRAMACCESSDATA  out  8  staged CPU write byte
- VDPVRAMACCESSADDRTMP  out  ADDR_W  staged new access address
- VDPVRAMREADINGA  out  1  read-capture ack toggle
- reg_wr  out  1  one-cycle register-write strobe
- reg_num  out  6  register number
- reg_data  out  8  register data
- wr_overrun  out  1  one-cycle pulse: CPU write arrived while a prior write was still pending

Behaviour:
- Reset: all outputs 0; internal first_byte_pending = 0; latched low byte = 0.
  - Request toggles must equal their ack inputs after reset, so the arbiter sees no request. The arbiter resets its acks to 0.
- Toggle handshake: a request is pending while REQ != ACK. A request is issued by inverting REQ. A request is issued only when REQ == ACK.
- Control-port write, first byte (first_byte_pending = 0):
  - latch cpu_din as low byte;
  - set first_byte_pending = 1;
  - no other outputs change.
- Control-port write, second byte (first_byte_pending = 1): clear first_byte_pending, then act on cpu_din[7]:
  - cpu_din[7] = 1: register write.
    - Next cycle: reg_wr = 1 for exactly 1 cycle, reg_num = cpu_din[5:0], reg_data = latched low byte.
  - cpu_din[7] = 0: address set.
    - VDPVRAMACCESSADDRTMP <= {addr_high, cpu_din[5:0], low byte}.
    - Toggle VDPVRAMADDRSETREQ.
    - If additionally cpu_din[6] = 0 (read setup), toggle VDPVRAMRDREQ in the same cycle to request read-ahead.
    - If a request of either type is already pending, that toggle is suppressed; ADDRTMP is still updated.
- Data-port write:
  - VDPVRAMACCESSDATA <= cpu_din; clear first_byte_pending.
  - If WRREQ == WRACK, toggle WRREQ.
  - Otherwise the data is overwritten, WRREQ is not toggled (the single pending write now carries the new byte), and wr_overrun pulses 1 cycle.
- Data-port read:
  - cpu_dout holds the read buffer continuously (combinationally visible; no latency).
  - On the access, clear first_byte_pending and toggle VDPVRAMRDREQ for the next read-ahead.
  - If RDREQ != RDACK, the toggle is suppressed.
- Control-port read (status read, decoded elsewhere): clears first_byte_pending only.
- Read capture: when DOTSTATE == 2'b01 and VDPVRAMREADINGR != VDPVRAMREADINGA:
  - read buffer <= PRAMDBI;
  - VDPVRAMREADINGA <= VDPVRAMREADINGR.
  - Capture is independent of CPU activity. If a CPU data read and a capture coincide, the CPU sees the old buffer value; the buffer updates at the clock edge.
- cpu_port 2/3 and cycles with cpu_req = 0: no state change except read capture.
- Simultaneous events:
  - A CPU access in the same cycle an ack toggles uses the registered (pre-edge) comparison. A request may therefore be judged pending one cycle longer; this is acceptable.
  - Both address-set and read toggles may flip in the same cycle.
- Reset mid-operation returns all toggles to 0 and abandons any pending request.

Test Plan:
- Reset, then idle 20 cycles -> all REQ = 0, reg_wr never 1, cpu_dout = 0.
- Control writes 0x34, 0x52 with addr_high = 0x01:
  - ADDRTMP = 0x05234;
  - ADDRSETREQ toggles;
  - RDREQ unchanged (bit6 = 1).
- Control writes 0x00, 0x12, then arbiter acks both; drive READINGR toggle with PRAMDBI = 0xA5 at DOTSTATE = 01:
  - ADDRSETREQ and RDREQ both toggle;
  - buffer = 0xA5, READINGA follows;
  - subsequent data read returns 0xA5 and toggles RDREQ.
- Control writes 0x07, 0x87 -> one-cycle reg_wr with reg_num = 7, reg_data = 0x07; no VRAM request toggles.
- Data writes 0x11 then 0x22 with WRACK held -> WRREQ toggles once, ACCESSDATA = 0x22, wr_overrun pulses once.
- Control writes 0x34, then a status read, then control write 0x40 -> 0x40 is treated as a first byte; no address set occurs.
